regfile_2w_sb: RTL and testbench

- Parametrised successor to the single-write 32x32 register file: configurable width and depth, two write ports, optional write-to-read bypass, and a per-register busy scoreboard.
- Sits between decode and writeback of the multi-issue core.
- Decode marks destinations busy at issue. Writeback ports clear busy and update data.
- Read ports report data plus a busy flag so decode can stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_2w_sb_scoreboard.sv | 51 +++++
 rtl/regfile_2w_sb.sv | 115 +++++++++++
 tb/tb_regfile_2w_sb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the two-write-port register file.
//   DEF_XLEN / DEF_NREG : default data width / register count
//   ZERO_IDX            : index of the hardwired-zero register
//   clog2_aw()          : address width for a given register count
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_IDX = 0;

  // Address width; a 2-entry file still needs one address bit.
  function automatic int clog2_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_2w_sb_scoreboard.sv
// Per-register busy scoreboard.
//   clk, reset          : clock, synchronous active-high reset
//   issue_valid/rd      : mark a destination busy
//   flush               : clear every busy bit
//   we0/rd0, we1/rd1    : writeback ports, clear busy on their rd
//   busy_vec            : bit i = register i has an outstanding write
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int AW       = clog2_aw(DEF_NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  input  logic            we0,
  input  logic [AW-1:0]   rd0,
  input  logic            we1,
  input  logic [AW-1:0]   rd1,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    logic set_i, clr_i;
    assign set_i = issue_valid && (issue_rd == AW'(i));
    assign clr_i = (we0 && (rd0 == AW'(i))) || (we1 && (rd1 == AW'(i)));
    if (ZERO_REG && (i == ZERO_IDX)) begin : g_zero
      assign busy_nxt[i] = 1'b0;
    end else begin : g_norm
      // A new issue beats a same-cycle writeback: the younger producer
      // is still outstanding even though an older one just retired.
      assign busy_nxt[i] = set_i ? 1'b1 :
                           flush ? 1'b0 :
                           clr_i ? 1'b0 : busy_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_2w_sb.sv
// Parameterised register file: two write ports (port 1 wins on a
// collision), two combinational read ports with optional write bypass,
// and a busy scoreboard for RAW stall detection in decode.
//   clk, reset               : clock, synchronous active-high reset
//   rs1/rs2 -> rv1/rv2       : combinational read data
//   rv1_busy/rv2_busy        : read register has an outstanding write
//   we0/rd0/wdata0           : write port 0
//   we1/rd1/wdata1           : write port 1 (higher priority)
//   issue_valid/issue_rd     : mark destination busy
//   flush                    : clear all busy bits, data kept
//   busy_vec                 : scoreboard state
//   wr_conflict              : both write ports hit the same rd last cycle
module regfile_2w_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREG     = DEF_NREG,
  parameter  bit BYPASS   = 1'b1,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = clog2_aw(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic            rv1_busy,
  output logic            rv2_busy,
  input  logic            we0,
  input  logic [AW-1:0]   rd0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic            wr_conflict
);

  localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

  logic [NREG-1:0][XLEN-1:0] mem;

  // Writes to the zero register are dropped before they reach the array.
  logic wen0, wen1;
  assign wen0 = we0 && !(ZERO_REG && (rd0 == ZIDX));
  assign wen1 = we1 && !(ZERO_REG && (rd1 == ZIDX));

  always_ff @(posedge clk) begin
    if (reset) begin
      mem         <= '0;
      wr_conflict <= 1'b0;
    end else begin
      // Port 1 is written last so it overrides port 0 on the same rd.
      if (wen0) mem[rd0] <= wdata0;
      if (wen1) mem[rd1] <= wdata1;
      wr_conflict <= we0 && we1 && (rd0 == rd1);
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .we0         (we0),
    .rd0         (rd0),
    .we1         (we1),
    .rd1         (rd1),
    .busy_vec    (busy_vec)
  );

  // Read ports, handled identically via a small generate array.
  logic [1:0][AW-1:0]   rs;
  logic [1:0][XLEN-1:0] rv;
  logic [1:0]           rbusy;

  assign rs = {rs2, rs1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] data;
    logic            byp;
    always_comb begin
      data = mem[rs[p]];
      byp  = 1'b0;
      if (BYPASS) begin
        if (wen1 && (rd1 == rs[p])) begin
          data = wdata1;
          byp  = 1'b1;
        end else if (wen0 && (rd0 == rs[p])) begin
          data = wdata0;
          byp  = 1'b1;
        end
      end
      if (ZERO_REG && (rs[p] == ZIDX)) data = '0;
    end
    assign rv[p] = data;
    // A value being forwarded this cycle is no longer a hazard.
    assign rbusy[p] = busy_vec[rs[p]] && !byp;
  end

  assign rv1      = rv[0];
  assign rv2      = rv[1];
  assign rv1_busy = rbusy[0];
  assign rv2_busy = rbusy[1];

endmodule

// File: tb/tb_regfile_2w_sb.sv
module tb_regfile_2w_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs1, rs2, rd0, rd1, issue_rd;
  logic            we0, we1, issue_valid, flush;
  logic [XLEN-1:0] wdata0, wdata1;

  logic [XLEN-1:0] rv1, rv2, b_rv1, b_rv2;
  logic            rv1_busy, rv2_busy, b_rv1_busy, b_rv2_busy;
  logic [NREG-1:0] busy_vec, b_busy_vec;
  logic            wr_conflict, b_wr_conflict;

  always #5 clk = ~clk;

  regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
    .rv1_busy(rv1_busy), .rv2_busy(rv2_busy),
    .we0(we0), .rd0(rd0), .wdata0(wdata0), .we1(we1), .rd1(rd1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict));

  regfile_2w_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(b_rv1), .rv2(b_rv2),
    .rv1_busy(b_rv1_busy), .rv2_busy(b_rv2_busy),
    .we0(we0), .rd0(rd0), .wdata0(wdata0), .we1(we1), .rd1(rd1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .busy_vec(b_busy_vec), .wr_conflict(b_wr_conflict));

  typedef enum int {S_RV1, S_RV2, S_B1, S_B2, S_BV, S_WC, S_NB_RV1, S_NB_B1} sel_t;
  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t keep[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] probe(sel_t s);
    case (s)
      S_RV1:    return rv1;
      S_RV2:    return rv2;
      S_B1:     return 32'(rv1_busy);
      S_B2:     return 32'(rv2_busy);
      S_BV:     return busy_vec;
      S_WC:     return 32'(wr_conflict);
      S_NB_RV1: return b_rv1;
      default:  return 32'(b_rv1_busy);
    endcase
  endfunction

  // Monitor: outputs are combinational or registered, so each expectation
  // is tagged with the cycle it becomes observable and checked mid-cycle.
  always @(negedge clk) begin
    logic [31:0] got;
    keep = {};
    foreach (q[i]) begin
      if (q[i].cyc == cycle) begin
        got = probe(q[i].sel);
        n_checks++;
        if (got !== q[i].exp) begin
          n_errors++;
          $display("FAIL %s @cyc %0d: got %h, want %h", q[i].name, cycle, got, q[i].exp);
        end
      end else if (q[i].cyc < cycle) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: expectation for cyc %0d never sampled", q[i].name, q[i].cyc);
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
  end

  task automatic expect_at(input int dc, input sel_t s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cycle + dc; e.sel = s; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; issue_valid = 0; flush = 0; reset = 0;
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0; rd0 = 0; rd1 = 0; issue_rd = 0;
    we0 = 0; we1 = 0; issue_valid = 0; flush = 0; wdata0 = 0; wdata1 = 0;
    tick();
    tick();
    reset = 0;

    // Reset state
    rs1 = 5; rs2 = 31;
    expect_at(0, S_RV1, 32'h0, "rst_rv1");
    expect_at(0, S_RV2, 32'h0, "rst_rv2");
    expect_at(0, S_BV,  32'h0, "rst_busy_vec");
    expect_at(0, S_WC,  32'h0, "rst_wr_conflict");
    tick();

    // Issue r7, then writeback with bypass
    issue_valid = 1; issue_rd = 7; rs1 = 7;
    expect_at(0, S_B1, 32'h0, "pre_issue_busy");
    tick(); idle();
    expect_at(0, S_BV, 32'h80, "issue7_busy_vec");
    expect_at(0, S_B1, 32'h1, "issue7_rv1_busy");
    tick();
    we0 = 1; rd0 = 7; wdata0 = 32'hDEADBEEF;
    expect_at(0, S_RV1, 32'hDEADBEEF, "bypass_rv1");
    expect_at(0, S_B1,  32'h0, "bypass_rv1_busy");
    expect_at(0, S_BV,  32'h80, "wb_cycle_busy_vec");
    expect_at(0, S_NB_RV1, 32'h0, "nobyp_old_rv1");
    expect_at(0, S_NB_B1,  32'h1, "nobyp_busy");
    tick(); idle();
    expect_at(0, S_BV,  32'h0, "wb_clear_busy_vec");
    expect_at(0, S_RV1, 32'hDEADBEEF, "stored_rv1");
    expect_at(0, S_NB_RV1, 32'hDEADBEEF, "nobyp_new_rv1");
    expect_at(0, S_NB_B1,  32'h0, "nobyp_busy_clr");
    tick();

    // BYPASS=0 instance: same-cycle read sees old value of r12
    we0 = 1; rd0 = 12; wdata0 = 32'hA5A5A5A5; rs1 = 12;
    expect_at(0, S_NB_RV1, 32'h0, "nobyp_r12_old");
    expect_at(0, S_RV1, 32'hA5A5A5A5, "byp_r12");
    tick(); idle();
    expect_at(0, S_NB_RV1, 32'hA5A5A5A5, "nobyp_r12_new");
    tick();

    // Dual-write conflict on r3
    we0 = 1; rd0 = 3; wdata0 = 32'h11; we1 = 1; rd1 = 3; wdata1 = 32'h22; rs2 = 3;
    expect_at(0, S_RV2, 32'h22, "conflict_bypass_prio");
    tick(); idle();
    expect_at(0, S_RV2, 32'h22, "conflict_stored");
    expect_at(0, S_WC,  32'h1,  "conflict_flag");
    tick();
    expect_at(0, S_WC, 32'h0, "conflict_flag_clear");

    // Zero register: write and issue to r0 have no effect
    we1 = 1; rd1 = 0; wdata1 = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0; rs1 = 0;
    expect_at(0, S_RV1, 32'h0, "zero_rv1_same");
    expect_at(0, S_B1,  32'h0, "zero_busy_same");
    tick(); idle();
    expect_at(0, S_RV1, 32'h0, "zero_rv1_next");
    expect_at(0, S_BV,  32'h0, "zero_busy_vec");
    expect_at(0, S_NB_RV1, 32'h0, "zero_nobyp_rv1");
    tick();

    // Flush vs issue: seed data in r2/r9, make 2/4/9 busy
    we0 = 1; rd0 = 2; wdata0 = 32'h1234; we1 = 1; rd1 = 9; wdata1 = 32'h9999;
    tick(); idle();
    expect_at(0, S_WC, 32'h0, "diff_rd_no_conflict");
    issue_valid = 1; issue_rd = 2; tick();
    issue_rd = 4; tick();
    issue_rd = 9; tick(); idle();
    expect_at(0, S_BV, 32'h214, "three_busy");
    flush = 1; issue_valid = 1; issue_rd = 4; rs1 = 2; rs2 = 9;
    tick(); idle();
    expect_at(0, S_BV,  32'h10, "flush_issue_busy_vec");
    expect_at(0, S_RV1, 32'h1234, "flush_keeps_r2");
    expect_at(0, S_RV2, 32'h9999, "flush_keeps_r9");
    expect_at(0, S_B2,  32'h0, "flush_r9_not_busy");
    tick();

    // Issue beats same-cycle writeback to the same register
    issue_valid = 1; issue_rd = 5; we0 = 1; rd0 = 5; wdata0 = 32'h77; rs1 = 5;
    expect_at(0, S_RV1, 32'h77, "issue_wb_bypass");
    expect_at(0, S_B1,  32'h0, "issue_wb_busy_same");
    tick(); idle();
    expect_at(0, S_BV,  32'h30, "issue_beats_wb");
    expect_at(0, S_RV1, 32'h77, "issue_wb_stored");
    expect_at(0, S_B1,  32'h1, "issue_wb_busy_next");
    tick();

    // Reset mid-write discards the write and clears state
    reset = 1; we0 = 1; rd0 = 6; wdata0 = 32'h55; rs1 = 6; rs2 = 3;
    tick(); idle();
    expect_at(0, S_RV1, 32'h0, "reset_drops_write");
    expect_at(0, S_RV2, 32'h0, "reset_clears_r3");
    expect_at(0, S_BV,  32'h0, "reset_busy_vec");
    expect_at(0, S_WC,  32'h0, "reset_wr_conflict");
    tick();

    // Drain with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      foreach (q[i]) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for cyc %0d", q[i].name, q[i].cyc);
      end
      q = {};
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
